// File: rtl/simon_seq_player.sv
// -----------------------------------------------------------------------------
// SimonSeqPlayer (simon_seq_player)
//
// Stores the colours drawn from the Simon LFSR into a sequence memory and
// replays them to the LED driver. Each colour is lit for ON_CYCLES clocks and
// is then followed by OFF_CYCLES blank clocks. A combinational read port gives
// the input-checker stage access to any stored entry.
//
// Ports:
//   clk         system clock; all state changes happen on the rising edge
//   reset       synchronous, active-high reset
//   i_rand_in   colour from the LFSR
//   i_append    store i_rand_in at index o_len, then increment o_len
//   i_start     begin playback of entries 0..o_len-1
//   i_clear     set o_len to 0 (new game)
//   i_rd_idx    checker read index
//   o_rd_color  mem[i_rd_idx], or 00 when i_rd_idx >= o_len
//   o_len       number of stored colours
//   o_full      o_len == MAX_LEN
//   o_busy      high whenever the player is not idle
//   o_led_valid registered; high while a colour is shown
//   o_led_color registered; colour being shown, 00 while blank
//   o_done      registered one-cycle pulse at the end of playback
// -----------------------------------------------------------------------------
module simon_seq_player #(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_rand_in,
  input  logic             i_append,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [LEN_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_color,
  output logic [LEN_W-1:0] o_len,
  output logic             o_full,
  output logic             o_busy,
  output logic             o_led_valid,
  output logic [1:0]       o_led_color,
  output logic             o_done
);

  // Memory address width; MAX_LEN == 1 still needs a one-bit address.
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // The phase counter must hold the longer of the two phase lengths.
  localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [LEN_W-1:0] r_playIdx;
  logic [LEN_W-1:0] w_nextPlayIdx;
  logic [LEN_W-1:0] r_len;
  logic             r_ledValid;
  logic [1:0]       r_ledColor;
  logic             r_done;
  logic             w_full;
  logic             w_doAppend;
  logic             w_doClear;
  logic             w_lastEntry;

  logic [1:0]       r_mem [0:MAX_LEN-1];

  assign w_full      = (r_len == MAX_LEN_V);
  // Only meaningful while playing, where len is at least 1.
  assign w_lastEntry = (r_playIdx == r_len - LEN_W'(1));

  // Next-state logic. Commands are accepted only in IDLE, one per cycle,
  // with clear beating append beating start.
  always_comb begin
    w_nextState   = r_state;
    w_nextCnt     = r_cnt;
    w_nextPlayIdx = r_playIdx;
    w_doAppend    = 1'b0;
    w_doClear     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_clear) begin
          w_doClear = 1'b1;
        end else if (i_append) begin
          w_doAppend = !w_full;
        end else if (i_start) begin
          if (r_len != '0) begin
            w_nextState   = ON;
            w_nextPlayIdx = '0;
            w_nextCnt     = ON_LOAD;
          end else begin
            w_nextState = DONE;
          end
        end
      end
      ON: begin
        if (r_cnt == '0) begin
          w_nextState = OFF;
          w_nextCnt   = OFF_LOAD;
        end else begin
          w_nextCnt = r_cnt - CNT_W'(1);
        end
      end
      OFF: begin
        if (r_cnt == '0) begin
          if (w_lastEntry) begin
            w_nextState = DONE;
          end else begin
            w_nextState   = ON;
            w_nextPlayIdx = r_playIdx + LEN_W'(1);
            w_nextCnt     = ON_LOAD;
          end
        end else begin
          w_nextCnt = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, length and the LED/done outputs. The LED outputs are registered
  // from the next state so they line up with the cycle the state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_playIdx  <= '0;
      r_len      <= '0;
      r_ledValid <= 1'b0;
      r_ledColor <= 2'b00;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_playIdx <= w_nextPlayIdx;
      if (w_doClear) begin
        r_len <= '0;
      end else if (w_doAppend) begin
        r_len <= r_len + LEN_W'(1);
      end
      r_ledValid <= (w_nextState == ON);
      r_ledColor <= (w_nextState == ON) ? r_mem[w_nextPlayIdx[IDX_W-1:0]] : 2'b00;
      r_done     <= (w_nextState == DONE);
    end
  end

  // Sequence memory; deliberately not cleared by reset. Appends only happen
  // while len < MAX_LEN, so the truncated index is always in range.
  always_ff @(posedge clk) begin
    if (!reset && w_doAppend) begin
      r_mem[r_len[IDX_W-1:0]] <= i_rand_in;
    end
  end

  assign o_rd_color  = (i_rd_idx < r_len) ? r_mem[i_rd_idx[IDX_W-1:0]] : 2'b00;
  assign o_len       = r_len;
  assign o_full      = w_full;
  assign o_busy      = (r_state != IDLE);
  assign o_led_valid = r_ledValid;
  assign o_led_color = r_ledColor;
  assign o_done      = r_done;

endmodule
